spi_xfer_ctrl: RTL and testbench

- Parametrised transfer controller for the Wishbone–SPI interface; successor to the fixed 3-bit state logic.
- Adds a built-in SCK prescaler, CPOL/CPHA modes, multiple chip selects, a full-duplex mode, a configurable frame width and a done/error handshake.
- Sits between the Wishbone slave decode (which drives cmd/wr/rd/req) and the SPI pins.

---
 rtl/spi_xfer_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_xfer_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller between the Wishbone slave decode and the SPI pins: config register plus one-frame transfers.
// Latency: register access completes 2 clk after req; a frame completes (2*DATA_W+2)*(clkdiv+1) clk after entry.
// Backpressure: none queued; req is sampled only in IDLE and ignored while busy, so the requester must wait for done/err.
module spi_xfer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int NUM_CS  = 4,
    parameter int CS_W    = 2,
    parameter int DIV_W   = 4,
    parameter int DEF_DIV = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              cmd_i,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              busy_o,
    output logic [2:0]        state_o,
    output logic              sck_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [NUM_CS-1:0] cs_n_o
);

    // Config word bit positions: clkdiv at the bottom, then cpha, cpol, cs_sel.
    localparam int CPHA_B = DIV_W;
    localparam int CPOL_B = DIV_W + 1;
    localparam int CSS_B  = DIV_W + 2;
    // A frame has 2*DATA_W sck edges, then one half-period to release cs and one more to finish.
    localparam int NEDGE  = 2 * DATA_W;
    localparam int EW     = $clog2(NEDGE + 3);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_REG_RD  = 3'b001,
        S_REG_WR  = 3'b010,
        S_DOUT    = 3'b011,
        S_DIN     = 3'b100,
        S_DUPLEX  = 3'b101,
        S_CS_HOLD = 3'b110,
        S_UNUSED  = 3'b111
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    clkdiv_q, clkdiv_d;
    logic                cpha_q, cpha_d;
    logic                cpol_q, cpol_d;
    logic [CS_W-1:0]     cs_sel_q, cs_sel_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic [EW-1:0]       edge_q, edge_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic [DATA_W-1:0]   rx_q, rx_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sck_q, sck_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    state_e              req_st;
    logic [NUM_CS-1:0]   cs_dec;
    logic [DATA_W-1:0]   cfg_word;
    logic [EW-1:0]       edge_nxt;
    logic                half_end;
    logic                shift_edge;

    // Decode the request qualifiers into the target state; S_IDLE marks an illegal combination.
    always_comb begin
        req_st = S_IDLE;
        case ({cmd_i, rd_i, wr_i})
            3'b110:  req_st = S_REG_RD;
            3'b101:  req_st = S_REG_WR;
            3'b001:  req_st = S_DOUT;
            3'b010:  req_st = S_DIN;
            3'b011:  req_st = S_DUPLEX;
            default: req_st = S_IDLE;
        endcase
    end

    // One-hot-low chip select; an out-of-range cs_sel asserts nothing but the frame still runs.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_sel_q == CS_W'(i)) begin
                cs_dec[i] = 1'b0;
            end
        end
    end

    // Pack the config fields for read-back; unused upper bits read as zero.
    always_comb begin
        cfg_word                   = '0;
        cfg_word[DIV_W-1:0]        = clkdiv_q;
        cfg_word[CPHA_B]           = cpha_q;
        cfg_word[CPOL_B]           = cpol_q;
        cfg_word[CSS_B +: CS_W]    = cs_sel_q;
    end

    assign half_end   = (cnt_q == clkdiv_q);
    assign edge_nxt   = edge_q + EW'(1);
    // cpha=0 shifts on even edges (MSB already out at entry); cpha=1 shifts on odd edges.
    assign shift_edge = cpha_q ? edge_nxt[0] : ~edge_nxt[0];

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        state_d  = state_q;
        clkdiv_d = clkdiv_q;
        cpha_d   = cpha_q;
        cpol_d   = cpol_q;
        cs_sel_d = cs_sel_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cs_n_d   = cs_n_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                sck_d  = cpol_q;
                cnt_d  = '0;
                edge_d = '0;
                mosi_d = 1'b0;
                if (req_i) begin
                    state_d = req_st;
                    if (req_st == S_IDLE) begin
                        err_d = 1'b1;
                    end else if (req_st == S_DOUT || req_st == S_DIN || req_st == S_DUPLEX) begin
                        // Entry edge: select the slave and capture the frame so later wdata changes are ignored.
                        cs_n_d = cs_dec;
                        rx_d   = '0;
                        if (cpha_q) begin
                            tx_d   = wdata_i;
                            mosi_d = 1'b0;
                        end else begin
                            tx_d   = {wdata_i[DATA_W-2:0], 1'b0};
                            mosi_d = (req_st == S_DIN) ? 1'b0 : wdata_i[DATA_W-1];
                        end
                    end
                end
            end
            S_REG_RD: begin
                rdata_d = cfg_word;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            S_REG_WR: begin
                clkdiv_d = wdata_i[DIV_W-1:0];
                cpha_d   = wdata_i[CPHA_B];
                cpol_d   = wdata_i[CPOL_B];
                cs_sel_d = wdata_i[CSS_B +: CS_W];
                // Idle level follows the new cpol from the very next cycle.
                sck_d    = wdata_i[CPOL_B];
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            S_DOUT, S_DIN, S_DUPLEX: begin
                if (half_end) begin
                    cnt_d  = '0;
                    edge_d = edge_nxt;
                    if (edge_nxt <= EW'(NEDGE)) begin
                        sck_d = ~sck_q;
                        if (shift_edge) begin
                            mosi_d = (state_q == S_DIN) ? 1'b0 : tx_q[DATA_W-1];
                            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                        end else begin
                            rx_d = {rx_q[DATA_W-2:0], miso_i};
                        end
                    end else begin
                        // All bits exchanged: release chip select and publish the received frame.
                        state_d = S_CS_HOLD;
                        cs_n_d  = '1;
                        if (state_q != S_DOUT) begin
                            rdata_d = rx_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_CS_HOLD: begin
                if (half_end) begin
                    cnt_d   = '0;
                    edge_d  = '0;
                    mosi_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                // The unused encoding falls back to IDLE.
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset forces the pins idle immediately, even mid-frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            clkdiv_q <= DIV_W'(DEF_DIV);
            cpha_q   <= 1'b0;
            cpol_q   <= 1'b0;
            cs_sel_q <= '0;
            cnt_q    <= '0;
            edge_q   <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_n_q   <= '1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            clkdiv_q <= clkdiv_d;
            cpha_q   <= cpha_d;
            cpol_q   <= cpol_d;
            cs_sel_q <= cs_sel_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cs_n_q   <= cs_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (state_q != S_IDLE);
    assign rdata_o = rdata_q;
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign sck_o   = sck_q;
    assign mosi_o  = mosi_q;
    assign cs_n_o  = cs_n_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: SPI slave model plus transaction-level expectations.
// Latency: checks frame timing in clk cycles from the entry cycle.
// Backpressure: holds req across a busy frame to confirm no queueing.
module tb_spi_xfer_ctrl;

    logic       clk;
    logic       rst_n;
    logic       req, cmd, wr, rd;
    logic [7:0] wdata;
    logic [7:0] rdata, rdata2;
    logic       done, err, busy, done2, err2, busy2;
    logic [2:0] state, state2;
    logic       sck, mosi, sck2, mosi2;
    logic       miso_drv;
    logic       loop_mode;
    logic [3:0] cs_n, cs_n2;

    int         tests_run;
    int         tests_failed;
    logic [7:0] cur_cfg;
    logic [7:0] exp_rdata;

    spi_xfer_ctrl #(.DATA_W(8), .NUM_CS(4), .CS_W(2), .DIV_W(4), .DEF_DIV(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .cmd_i(cmd), .wr_i(wr), .rd_i(rd),
        .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .err_o(err), .busy_o(busy),
        .state_o(state), .sck_o(sck), .mosi_o(mosi), .miso_i(loop_mode ? mosi : miso_drv),
        .cs_n_o(cs_n)
    );

    // Second instance with a 3-bit cs_sel so an out-of-range select can be exercised.
    spi_xfer_ctrl #(.DATA_W(8), .NUM_CS(4), .CS_W(3), .DIV_W(3), .DEF_DIV(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .cmd_i(cmd), .wr_i(wr), .rd_i(rd),
        .wdata_i(wdata), .rdata_o(rdata2), .done_o(done2), .err_o(err2), .busy_o(busy2),
        .state_o(state2), .sck_o(sck2), .mosi_o(mosi2), .miso_i(miso_drv),
        .cs_n_o(cs_n2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_xfer(input logic [2:0] s);
        return (s == 3'b011) || (s == 3'b100) || (s == 3'b101);
    endfunction

    task automatic reg_wr(input logic [7:0] w, output int n_done, output logic sck_idle);
        @(negedge clk); req = 1; cmd = 1; rd = 0; wr = 1; wdata = w;
        @(negedge clk); req = 0;
        n_done = 0; sck_idle = 1'bx;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) sck_idle = sck;
            if (done === 1'b1) n_done++;
        end
        cmd = 0; wr = 0;
        cur_cfg = w;
    endtask

    task automatic reg_rd(output int n_done, output logic [7:0] val);
        @(negedge clk); req = 1; cmd = 1; rd = 1; wr = 0;
        @(negedge clk); req = 0;
        n_done = 0; val = 'x;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) val = rdata;
            if (done === 1'b1) n_done++;
        end
        cmd = 0; rd = 0;
    endtask

    // Runs one frame while acting as the SPI slave; returns observations only.
    task automatic xfer(input logic r, input logic w, input logic [7:0] wd, input logic [7:0] sw,
                        input bit loop, input bit hold,
                        output logic [2:0] st_e, output int t_done, output int cs_low,
                        output int toggles, output logic [3:0] cs_and, output int n_done,
                        output int n_entries, output logic [7:0] rd_done, output bit mosi_hi,
                        output logic [7:0] slave_got);
        logic       cpha;
        logic [7:0] s_tx;
        logic [7:0] s_rx;
        logic       prev_sck;
        logic [2:0] prev_st;
        bit         seen;
        cpha = cur_cfg[4];
        @(negedge clk);
        s_tx = sw; s_rx = '0; loop_mode = loop;
        if (!cpha) begin miso_drv = sw[7]; s_tx = {sw[6:0], 1'b0}; end
        else miso_drv = 1'b0;
        req = 1; cmd = 0; rd = r; wr = w; wdata = wd;
        prev_sck = sck; prev_st = state;
        st_e = 'x; t_done = -1; cs_low = 0; toggles = 0; cs_and = '1; n_done = 0;
        n_entries = 0; rd_done = 'x; mosi_hi = 0; seen = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (c == 0) begin st_e = state; if (!hold) req = 0; end
            if (c == 1) wdata = ~wd;
            if (is_xfer(state) && !is_xfer(prev_st)) n_entries++;
            prev_st = state;
            if (sck !== prev_sck) begin
                toggles++;
                if (toggles <= 16) begin
                    if (((toggles % 2) == 1) != cpha) s_rx = {s_rx[6:0], mosi};
                    else begin miso_drv = s_tx[7]; s_tx = {s_tx[6:0], 1'b0}; end
                end
            end
            prev_sck = sck;
            if (cs_n !== 4'hF) cs_low++;
            cs_and &= cs_n;
            if (mosi === 1'b1) mosi_hi = 1;
            if (done === 1'b1) begin
                n_done++;
                if (!seen) begin t_done = c; rd_done = rdata; seen = 1; req = 0; end
            end
            if (seen && c >= t_done + 4) break;
        end
        req = 0; rd = 0; wr = 0; loop_mode = 0;
        slave_got = s_rx;
    endtask

    task automatic test_reset;
        int nd; logic [7:0] v;
        rst_n = 0; req = 0; cmd = 0; wr = 0; rd = 0; wdata = 0; miso_drv = 0; loop_mode = 0;
        repeat (3) @(negedge clk);
        tests_run++; if (state !== 3'b000) begin tests_failed++; $display("FAIL reset_state got %b exp 000", state); end
        tests_run++; if (sck !== 1'b0 || mosi !== 1'b0) begin tests_failed++; $display("FAIL reset_pins sck=%b mosi=%b exp 0,0", sck, mosi); end
        tests_run++; if (cs_n !== 4'hF) begin tests_failed++; $display("FAIL reset_cs got %b exp 1111", cs_n); end
        tests_run++; if (rdata !== 8'h00 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_outs rdata=%h done=%b err=%b busy=%b exp 00,0,0,0", rdata, done, err, busy); end
        rst_n = 1;
        cur_cfg = 8'h01; exp_rdata = 8'h00;
        reg_rd(nd, v);
        exp_rdata = 8'h01;
        tests_run++; if (v !== 8'h01) begin tests_failed++; $display("FAIL reset_cfg got %h exp 01", v); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL reset_cfg_done got %0d exp 1", nd); end
    endtask

    task automatic test_reg_access;
        int nd; logic s; logic [7:0] v;
        reg_wr(8'b01_1_0_0011, nd, s);
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL regwr_done got %0d exp 1", nd); end
        tests_run++; if (s !== 1'b1) begin tests_failed++; $display("FAIL regwr_sck_idle got %b exp 1", s); end
        reg_rd(nd, v);
        exp_rdata = 8'h63;
        tests_run++; if (v !== 8'h63) begin tests_failed++; $display("FAIL regrd_val got %h exp 63", v); end
        tests_run++; if (nd !== 1) begin tests_failed++; $display("FAIL regrd_done got %0d exp 1", nd); end
    endtask

    task automatic test_duplex_default;
        int nd, td, csl, tg, ne; logic s; logic [2:0] se; logic [3:0] ca; logic [7:0] rdv, sg; bit mh;
        reg_wr(8'h01, nd, s);
        xfer(1, 1, 8'hA5, 8'h00, 1, 0, se, td, csl, tg, ca, nd, ne, rdv, mh, sg);
        exp_rdata = 8'hA5;
        tests_run++; if (se !== 3'b101) begin tests_failed++; $display("FAIL dup_entry_state got %b exp 101", se); end
        tests_run++; if (rdv !== 8'hA5) begin tests_failed++; $display("FAIL dup_rdata got %h exp a5", rdv); end
        tests_run++; if (td !== 36) begin tests_failed++; $display("FAIL dup_done_time got %0d exp 36", td); end
        tests_run++; if (csl !== 34 || ca !== 4'b1110) begin tests_failed++; $display("FAIL dup_cs got %0d cycles mask %b exp 34 cycles mask 1110", csl, ca); end
        tests_run++; if (tg !== 16 || nd !== 1) begin tests_failed++; $display("FAIL dup_sck_done got %0d toggles %0d dones exp 16,1", tg, nd); end
    endtask

    task automatic test_cpha1;
        int nd, td, csl, tg, ne; logic s; logic [2:0] se; logic [3:0] ca; logic [7:0] rdv, sg; bit mh;
        reg_wr(8'b00_0_1_0000, nd, s);
        xfer(1, 0, 8'hFF, 8'h3C, 0, 0, se, td, csl, tg, ca, nd, ne, rdv, mh, sg);
        exp_rdata = 8'h3C;
        tests_run++; if (rdv !== 8'h3C) begin tests_failed++; $display("FAIL cpha1_din_rdata got %h exp 3c", rdv); end
        tests_run++; if (mh !== 1'b0) begin tests_failed++; $display("FAIL cpha1_din_mosi got high=%0d exp 0", mh); end
        tests_run++; if (td !== 18) begin tests_failed++; $display("FAIL cpha1_din_time got %0d exp 18", td); end
        xfer(0, 1, 8'hC3, 8'h5A, 0, 0, se, td, csl, tg, ca, nd, ne, rdv, mh, sg);
        tests_run++; if (sg !== 8'hC3) begin tests_failed++; $display("FAIL cpha1_dout_bits got %h exp c3", sg); end
        tests_run++; if (rdv !== exp_rdata) begin tests_failed++; $display("FAIL cpha1_dout_rdata got %h exp %h", rdv, exp_rdata); end
    endtask

    task automatic test_illegal;
        logic [2:0] combos [3];
        int ne, nd, nbad;
        combos = '{3'b111, 3'b000, 3'b100};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); req = 1; {cmd, rd, wr} = combos[k];
            ne = 0; nd = 0; nbad = 0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (i == 0) req = 0;
                if (err === 1'b1) ne++;
                if (done === 1'b1) nd++;
                if (state !== 3'b000) nbad++;
            end
            {cmd, rd, wr} = 3'b000;
            tests_run++; if (ne !== 1 || nd !== 0 || nbad !== 0) begin tests_failed++; $display("FAIL illegal_%b got err=%0d done=%0d nonidle=%0d exp 1,0,0", combos[k], ne, nd, nbad); end
        end
    endtask

    task automatic test_req_held;
        int nd, td, csl, tg, ne; logic [2:0] se; logic [3:0] ca; logic [7:0] rdv, sg; bit mh;
        xfer(0, 1, 8'h96, 8'h00, 0, 1, se, td, csl, tg, ca, nd, ne, rdv, mh, sg);
        tests_run++; if (ne !== 1 || nd !== 1) begin tests_failed++; $display("FAIL req_held got %0d entries %0d dones exp 1,1", ne, nd); end
        tests_run++; if (sg !== 8'h96) begin tests_failed++; $display("FAIL req_held_bits got %h exp 96", sg); end
    endtask

    task automatic test_cs_out_of_range;
        int nd, tg, csl, tdn; logic s; logic prev;
        reg_wr(8'b101_0_0_000, nd, s);
        @(negedge clk); req = 1; cmd = 0; rd = 0; wr = 1; wdata = 8'($urandom_range(0, 255));
        prev = sck2; tg = 0; csl = 0; nd = 0; tdn = -1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (c == 0) req = 0;
            if (sck2 !== prev) tg++;
            prev = sck2;
            if (cs_n2 !== 4'hF) csl++;
            if (done2 === 1'b1) begin nd++; if (tdn < 0) tdn = c; end
            if (tdn >= 0 && c >= tdn + 4) break;
        end
        wr = 0;
        tests_run++; if (tg !== 16) begin tests_failed++; $display("FAIL oos_toggles got %0d exp 16", tg); end
        tests_run++; if (csl !== 0) begin tests_failed++; $display("FAIL oos_cs got %0d low cycles exp 0", csl); end
        tests_run++; if (nd !== 1 || tdn !== 18) begin tests_failed++; $display("FAIL oos_done got %0d dones at %0d exp 1 at 18", nd, tdn); end
    endtask

    task automatic test_random;
        int nd, td, csl, tg, ne, m, h; logic s; logic [2:0] se; logic [3:0] ca;
        logic [7:0] rdv, sg, w, wd, sw, exp_sg;
        for (int n = 0; n < 16; n++) begin
            w = 8'($urandom_range(0, 255)); w[3:2] = 2'b00;
            reg_wr(w, nd, s);
            tests_run++; if (s !== w[5]) begin tests_failed++; $display("FAIL rnd%0d_idle got %b exp %b", n, s, w[5]); end
            m = $urandom_range(0, 2);
            wd = 8'($urandom_range(0, 255)); sw = 8'($urandom_range(0, 255));
            h = int'(w[3:0]) + 1;
            xfer(m != 0, m != 1, wd, sw, 0, 0, se, td, csl, tg, ca, nd, ne, rdv, s, sg);
            if (m != 0) exp_rdata = sw;
            exp_sg = (m == 1) ? 8'h00 : wd;
            tests_run++; if (rdv !== exp_rdata || sg !== exp_sg) begin tests_failed++; $display("FAIL rnd%0d_data mode %0d got rdata %h slave %h exp %h %h", n, m, rdv, sg, exp_rdata, exp_sg); end
            tests_run++; if (td !== 18 * h || csl !== 17 * h || tg !== 16 || nd !== 1) begin tests_failed++; $display("FAIL rnd%0d_timing got done@%0d cs%0d tog%0d nd%0d exp %0d %0d 16 1", n, td, csl, tg, nd, 18 * h, 17 * h); end
            tests_run++; if (ca !== ~(4'b0001 << w[7:6])) begin tests_failed++; $display("FAIL rnd%0d_cs got %b exp %b", n, ca, ~(4'b0001 << w[7:6])); end
        end
    endtask

    task automatic test_reset_mid_frame;
        int nd, td, csl, tg, ne; logic s; logic [2:0] se; logic [3:0] ca; logic [7:0] rdv, sg, wd; bit mh;
        logic prev; bit got;
        reg_wr(8'h01, nd, s);
        @(negedge clk); loop_mode = 1; req = 1; cmd = 0; rd = 1; wr = 1; wdata = 8'h5B;
        prev = sck; tg = 0; got = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 0) req = 0;
            if (sck !== prev) tg++;
            prev = sck;
            if (tg == 5) begin got = 1; break; end
        end
        tests_run++; if (!got) begin tests_failed++; $display("FAIL rstmid_reach_edge5 got %0d toggles exp 5", tg); end
        #2 rst_n = 0;
        #1;
        tests_run++; if (sck !== 1'b0 || cs_n !== 4'hF || state !== 3'b000) begin tests_failed++; $display("FAIL rstmid_immediate got sck=%b cs=%b st=%b exp 0 1111 000", sck, cs_n, state); end
        tests_run++; if (rdata !== 8'h00 || busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_outs got rdata=%h busy=%b exp 00 0", rdata, busy); end
        rd = 0; wr = 0; loop_mode = 0;
        @(negedge clk); rst_n = 1;
        cur_cfg = 8'h01; exp_rdata = 8'h00;
        wd = 8'($urandom_range(0, 255));
        xfer(1, 1, wd, 8'h00, 1, 0, se, td, csl, tg, ca, nd, ne, rdv, mh, sg);
        tests_run++; if (rdv !== wd || td !== 36 || nd !== 1) begin tests_failed++; $display("FAIL rstmid_recover got rdata %h done@%0d nd%0d exp %h 36 1", rdv, td, nd, wd); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        test_reset();
        test_reg_access();
        test_duplex_default();
        test_cpha1();
        test_illegal();
        test_req_held();
        test_cs_out_of_range();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
